// File: rtl/qsys_pwm_ctrl_if.sv
// Avalon-MM slave bus bundle for the PWM controller.
// The master side drives the address and write strobes; the slave side returns readdata.
interface qsys_pwm_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/qsys_pwm_ctrl.sv
// PWM generator: shared prescaler and period counter, per-channel duty compare, shadowed updates.
// Define QSYS_PWM_CTRL_IRQ_EN to add the STATUS DONE/MASK flops and the irq output.
module qsys_pwm_ctrl #(
  parameter int NCH = 4,
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] PERIOD_RST = CNT_W'(8'hFF)
) (
  input  logic           clk,
  input  logic           reset_n,
  qsys_pwm_ctrl_if.slave bus,
  output logic [NCH-1:0] out_port,
  output logic           irq
);

  logic             wr;
  logic [NCH-1:0]   enable;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      prescale;
  logic [15:0]      pre_cnt;
  logic [CNT_W-1:0] duty_sh [NCH];
  logic [CNT_W-1:0] duty_act [NCH];
  logic             running;
  logic             tick;
  logic             period_end;
  logic [31:0]      status;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  assign wr         = bus.chipselect & ~bus.write_n;
  assign running    = |enable;
  assign tick       = running && (pre_cnt == prescale);
  assign period_end = tick && (cnt == period_act);
  assign unused_ok  = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable    <= '0;
      period_sh <= PERIOD_RST;
      prescale  <= '0;
      for (int i = 0; i < NCH; i++)
        duty_sh[i] <= '0;
    end else if (wr) begin
      case (bus.address)
        3'd0: enable    <= bus.writedata[NCH-1:0];
        3'd1: period_sh <= bus.writedata[CNT_W-1:0];
        3'd2: prescale  <= bus.writedata[15:0];
        default: begin
          for (int i = 0; i < NCH; i++)
            if (bus.address == 3'(4 + i))
              duty_sh[i] <= bus.writedata[CNT_W-1:0];
        end
      endcase
    end
  end

  // Active copies track the shadows while idle and reload only at period end while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      period_act <= PERIOD_RST;
      out_port   <= '0;
      for (int i = 0; i < NCH; i++)
        duty_act[i] <= '0;
    end else if (!running) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      period_act <= period_sh;
      out_port   <= '0;
      for (int i = 0; i < NCH; i++)
        duty_act[i] <= duty_sh[i];
    end else begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (period_end) begin
        cnt        <= '0;
        period_act <= period_sh;
        for (int i = 0; i < NCH; i++)
          duty_act[i] <= duty_sh[i];
      end else if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end
      for (int i = 0; i < NCH; i++)
        out_port[i] <= enable[i] && (cnt < duty_act[i]);
    end
  end

`ifdef QSYS_PWM_CTRL_IRQ_EN
  logic done;
  logic mask;

  // A period end in the same clock as a clear keeps DONE set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
      mask <= 1'b0;
    end else begin
      if (period_end)
        done <= 1'b1;
      else if (wr && bus.address == 3'd3 && bus.writedata[0])
        done <= 1'b0;
      if (wr && bus.address == 3'd3)
        mask <= bus.writedata[8];
    end
  end

  assign irq    = done & mask;
  assign status = {23'd0, mask, 7'd0, done};
`else
  assign irq    = 1'b0;
  assign status = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0: rd_mux = 32'(enable);
      3'd1: rd_mux = 32'(period_sh);
      3'd2: rd_mux = 32'(prescale);
      3'd3: rd_mux = status;
      default: begin
        for (int i = 0; i < NCH; i++)
          if (bus.address == 3'(4 + i))
            rd_mux = 32'(duty_sh[i]);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bus.readdata <= '0;
    else
      bus.readdata <= rd_mux;
  end

endmodule

// File: tb/tb_qsys_pwm_ctrl.sv
// Bench for qsys_pwm_ctrl: directed scenarios plus random register traffic,
// checked every clock against a period/tick arithmetic model of the PWM.
module tb_qsys_pwm_ctrl;

  logic       clk;
  logic       reset_n;
  logic [3:0] out_port;
  logic       irq;

  qsys_pwm_ctrl_if bus();

  qsys_pwm_ctrl #(
    .NCH(4),
    .CNT_W(16),
    .PERIOD_RST(16'hFF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave),
    .out_port(out_port),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]  m_en;
  logic [15:0] m_shp;
  logic [15:0] m_pre;
  logic [15:0] m_actp;
  logic [15:0] m_shd [4];
  logic [15:0] m_actd [4];
  bit          m_done;
  bit          m_mask;
  int          m_n = 0;
  int          m_start = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_en = '0;
    m_shp = 16'hFF;
    m_pre = '0;
    m_actp = 16'hFF;
    for (int i = 0; i < 4; i++) begin
      m_shd[i] = '0;
      m_actd[i] = '0;
    end
    m_done = 0;
    m_mask = 0;
    m_start = m_n;
  endtask

  function automatic logic [31:0] rd_model(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_en);
      3'd1: return 32'(m_shp);
      3'd2: return 32'(m_pre);
`ifdef QSYS_PWM_CTRL_IRQ_EN
      3'd3: return {23'd0, m_mask, 7'd0, m_done};
`else
      3'd3: return 32'd0;
`endif
      default: return 32'(m_shd[a - 3'd4]);
    endcase
  endfunction

  // Counter value the next clock edge will see, in whole ticks since period start.
  function automatic int next_c();
    return (m_n - m_start) / (int'(m_pre) + 1);
  endfunction

  function automatic bit pend_next();
    int s;
    int j;
    s = int'(m_pre) + 1;
    j = m_n - m_start;
    return (m_en != 0) && (j % s == s - 1) && (j / s == int'(m_actp));
  endfunction

  task automatic step(input logic [2:0] a, input bit cs, input bit wn,
                      input logic [31:0] d);
    logic [31:0] e_rd;
    logic [3:0]  e_out;
    logic [31:0] e_irq;
    bit          pe;
    bit          w;
    int          c;
    bus.address = a;
    bus.chipselect = cs;
    bus.write_n = wn;
    bus.writedata = d;
    w = cs && !wn;
    e_rd = rd_model(a);
    e_out = '0;
    pe = 0;
    if (m_en == 0) begin
      m_actp = m_shp;
      m_actd = m_shd;
      m_start = m_n + 1;
    end else begin
      c = next_c();
      for (int i = 0; i < 4; i++)
        e_out[i] = m_en[i] && (c < int'(m_actd[i]));
      if (pend_next()) begin
        pe = 1;
        m_start = m_n + 1;
        m_actp = m_shp;
        m_actd = m_shd;
      end
    end
`ifdef QSYS_PWM_CTRL_IRQ_EN
    if (pe)
      m_done = 1;
    else if (w && a == 3'd3 && d[0])
      m_done = 0;
    if (w && a == 3'd3)
      m_mask = d[8];
`endif
    if (w) begin
      case (a)
        3'd0: m_en = d[3:0];
        3'd1: m_shp = d[15:0];
        3'd2: m_pre = d[15:0];
        3'd3: ;
        default: m_shd[a - 3'd4] = d[15:0];
      endcase
    end
    m_n++;
`ifdef QSYS_PWM_CTRL_IRQ_EN
    e_irq = 32'(m_done & m_mask);
`else
    e_irq = 32'd0;
`endif
    @(posedge clk);
    #1;
    chk("out_port", 32'(out_port), 32'(e_out));
    chk("readdata", bus.readdata, e_rd);
    chk("irq", 32'(irq), e_irq);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [2:0] a);
    step(a, 1'b0, 1'b1, 32'd0);
  endtask

  int  cnt_hi;
  bit  acc_or;
  bit  acc_and;
  bit  found;
  int  k;

  initial begin
    reset_n = 1'b0;
    bus.address = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(out_port), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rd", bus.readdata, 32'd0);
    reset_n = 1'b1;
    m_reset();

    for (int a = 0; a < 8; a++)
      rd(3'(a));

    // PERIOD=9, DUTY0=3: 3 high, 7 low per 10 clocks
    wr(3'd1, 32'd9);
    wr(3'd2, 32'd0);
    wr(3'd4, 32'd3);
    wr(3'd0, 32'd1);
    cnt_hi = 0;
    for (int i = 0; i < 20; i++) begin
      rd(3'd4);
      cnt_hi += int'(out_port[0]);
    end
    chk("t2_high", 32'(cnt_hi), 32'd6);

    // DUTY0=7 written mid-period applies only from the next period
    found = 0;
    for (int i = 0; i < 25 && !found; i++) begin
      if (next_c() == 5)
        found = 1;
      else
        rd(3'd1);
    end
    chk("t3_sync", 32'(found), 32'd1);
    wr(3'd4, 32'd7);
    cnt_hi = 0;
    for (int i = 0; i < 14; i++) begin
      rd(3'd4);
      cnt_hi += int'(out_port[0]);
    end
    chk("t3_high", 32'(cnt_hi), 32'd7);

    // duty 0 is always low, duty above period is always high
    wr(3'd0, 32'd0);
    wr(3'd5, 32'd0);
    wr(3'd6, 32'd12);
    wr(3'd0, 32'd7);
    acc_or = 0;
    acc_and = 1;
    for (int i = 0; i < 20; i++) begin
      rd(3'(i % 8));
      acc_or |= out_port[1];
      acc_and &= out_port[2];
    end
    chk("t4_ch1", 32'(acc_or), 32'd0);
    chk("t4_ch2", 32'(acc_and), 32'd1);

    // prescaled: 4 clocks high, 4 low; disable drops output next clock
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd3);
    wr(3'd1, 32'd1);
    wr(3'd4, 32'd1);
    wr(3'd0, 32'd1);
    cnt_hi = 0;
    for (int i = 0; i < 16; i++) begin
      rd(3'd2);
      cnt_hi += int'(out_port[0]);
    end
    chk("t5_high", 32'(cnt_hi), 32'd8);
    wr(3'd0, 32'd0);
    rd(3'd0);
    chk("t5_off", 32'(out_port), 32'd0);
    wr(3'd2, 32'd0);

`ifdef QSYS_PWM_CTRL_IRQ_EN
    wr(3'd3, 32'h101);
    wr(3'd1, 32'd4);
    wr(3'd0, 32'd1);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      rd(3'd3);
      if (irq) k = i;
    end
    chk("t6_rise", 32'(k), 32'd5);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend_next())
        found = 1;
      else
        rd(3'd3);
    end
    chk("t6_sync", 32'(found), 32'd1);
    wr(3'd3, 32'h101);
    chk("t6_setwins", 32'(irq), 32'd1);
    wr(3'd3, 32'h101);
    chk("t6_clr", 32'(irq), 32'd0);
    wr(3'd0, 32'd0);
`endif

    for (int i = 0; i < 600; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      bit          cs;
      bit          wn;
      a = 3'($urandom_range(0, 7));
      cs = 1'($urandom_range(0, 1));
      wn = ($urandom_range(0, 9) < 6);
      case (a)
        3'd0: d = $urandom_range(0, 15);
        3'd1: d = $urandom_range(0, 12);
        3'd2: d = $urandom_range(0, 3);
        3'd3: d = $urandom & 32'h0000_0101;
        default: d = $urandom_range(0, 14);
      endcase
      // prescaler changes are only issued while stopped
      if (a == 3'd2 && m_en != 0) begin
        a = 3'd0;
        d = 32'd0;
      end
      d = d | ($urandom & 32'hFFFF_0000);
      step(a, cs, wn, d);
    end

    // asynchronous reset in the middle of a running period
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd9);
    wr(3'd4, 32'd5);
    wr(3'd0, 32'd15);
    repeat (3) rd(3'd1);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out", 32'(out_port), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_rd", bus.readdata, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
    for (int a = 0; a < 8; a++)
      rd(3'(a));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
